// File: rtl/pix_frame_serializer.sv
// Captures a WIDTH*HEIGHT pixel frame on a valid/ready handshake and replays it row by row.
// Optional per-row even parity output is enabled by defining PIX_ROW_PARITY_EN.
module pix_frame_serializer #(
   parameter int WIDTH  = 120,
   parameter int HEIGHT = 52,
   localparam int ROWW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH*HEIGHT-1:0] pix_in,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   output logic [WIDTH-1:0]        row_data,
   output logic [ROWW-1:0]         row_idx,
   output logic                    row_valid,
   input  logic                    row_ready,
   output logic                    row_last,
   output logic [15:0]             frame_cnt
`ifdef PIX_ROW_PARITY_EN
   ,
   output logic                    row_parity
`endif
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [ROWW-1:0] LAST_ROW = ROWW'(HEIGHT - 1);

   state_t           state_p0;
   state_t           state_nxt;
   logic [WIDTH-1:0] frame_buf_p0 [HEIGHT];
   logic [ROWW-1:0]  row_idx_p0;
   logic [15:0]      frame_cnt_p0;
   logic             accept;
   logic             xfer;
   logic             at_last;

   assign at_last = (row_idx_p0 == LAST_ROW);
   assign accept  = pix_valid & pix_ready;
   assign xfer    = row_valid & row_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_p0 <= IDLE;
      else     state_p0 <= state_nxt;
   end

   // pix_ready in STREAM opens only on the final-row handshake so a new frame
   // can be captured without a bubble; it never looks at pix_valid.
   always_comb begin
      state_nxt = state_p0;
      pix_ready = 1'b0;
      row_valid = 1'b0;
      case (state_p0)
         IDLE: begin
            pix_ready = 1'b1;
            if (pix_valid) state_nxt = STREAM;
         end
         STREAM: begin
            row_valid = 1'b1;
            if (row_ready && at_last) begin
               pix_ready = 1'b1;
               state_nxt = pix_valid ? STREAM : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Row index returns to 0 at the end of every frame, so a capture never has to load it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_idx_p0   <= '0;
         frame_cnt_p0 <= '0;
      end else if (xfer) begin
         if (at_last) begin
            row_idx_p0   <= '0;
            frame_cnt_p0 <= frame_cnt_p0 + 16'd1;
         end else begin
            row_idx_p0   <= row_idx_p0 + ROWW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < HEIGHT; r++) frame_buf_p0[r] <= '0;
      end else if (accept) begin
         for (int r = 0; r < HEIGHT; r++) frame_buf_p0[r] <= pix_in[r*WIDTH +: WIDTH];
      end
   end

   assign row_data  = row_valid ? frame_buf_p0[row_idx_p0] : '0;
   assign row_idx   = row_idx_p0;
   assign row_last  = row_valid & at_last;
   assign frame_cnt = frame_cnt_p0;

`ifdef PIX_ROW_PARITY_EN
   function automatic logic row_xor(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction

   // Parity is folded at capture so the output path is a plain bit select.
   logic [HEIGHT-1:0] par_p0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_p0 <= '0;
      end else if (accept) begin
         for (int r = 0; r < HEIGHT; r++) par_p0[r] <= row_xor(pix_in[r*WIDTH +: WIDTH]);
      end
   end

   assign row_parity = row_valid & par_p0[row_idx_p0];
`endif

endmodule

// File: tb/tb_pix_frame_serializer.sv
// Scoreboard bench for pix_frame_serializer at WIDTH=8, HEIGHT=4.
module tb_pix_frame_serializer;

   localparam int W = 8;
   localparam int H = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [W*H-1:0] pix_in;
   logic          pix_valid;
   logic          pix_ready;
   logic [W-1:0]  row_data;
   logic [1:0]    row_idx;
   logic          row_valid;
   logic          row_ready;
   logic          row_last;
   logic [15:0]   frame_cnt;
`ifdef PIX_ROW_PARITY_EN
   logic          row_parity;
`endif

   pix_frame_serializer #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
      .row_last(row_last), .frame_cnt(frame_cnt)
`ifdef PIX_ROW_PARITY_EN
      , .row_parity(row_parity)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]   idx;
      logic [W-1:0] data;
      logic         last;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   xfers = 0;
   logic [15:0] exp_fc = 16'd0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [W*H-1:0] f);
      exp_t e;
      for (int r = 0; r < H; r++) begin
         e.idx  = 2'(r);
         e.data = f[r*W +: W];
         e.last = (r == H - 1);
         sb.push_back(e);
      end
   endtask

   // Every row handshake is popped against the scoreboard just before the edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && row_valid && row_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_row: got idx=%0d data=%h, required none", row_idx, row_data);
         end else begin
            e = sb.pop_front();
            if (row_idx !== e.idx || row_data !== e.data || row_last !== e.last) begin
               bad++;
               $display("FAIL row: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                        row_idx, row_data, row_last, e.idx, e.data, e.last);
            end
`ifdef PIX_ROW_PARITY_EN
            total++;
            if (row_parity !== ^e.data) begin
               bad++;
               $display("FAIL parity: got %b, required %b (data %h)", row_parity, ^e.data, e.data);
            end
`endif
         end
         xfers++;
      end
   end

   task automatic test_reset();
      rst = 1'b1; pix_valid = 1'b0; row_ready = 1'b0; pix_in = '0;
      tick(); tick();
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL reset_pix_ready: got %b, required 1", pix_ready); end
      total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL reset_row_valid: got %b, required 0", row_valid); end
      total++; if (row_last !== 1'b0 || row_idx !== 2'd0) begin bad++; $display("FAIL reset_row_idx_last: got %0d/%b, required 0/0", row_idx, row_last); end
      total++; if (row_data !== '0 || frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_data_cnt: got %h/%0d, required 0/0", row_data, frame_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_single_frame();
      push_frame(32'hA5C3_0FF0);
      pix_in = 32'hA5C3_0FF0; pix_valid = 1'b1; row_ready = 1'b1;
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL single_ready_idle: got %b, required 1", pix_ready); end
      tick();
      pix_valid = 1'b0; pix_in = 32'h1234_5678;
      for (int k = 0; k < H; k++) begin
         total++;
         if (row_valid !== 1'b1 || row_idx !== 2'(k)) begin
            bad++; $display("FAIL single_stream_k%0d: got valid=%b idx=%0d, required 1/%0d", k, row_valid, row_idx, k);
         end
         tick();
      end
      exp_fc = exp_fc + 16'd1;
      total++; if (row_valid !== 1'b0 || pix_ready !== 1'b1) begin bad++; $display("FAIL single_end: got valid=%b ready=%b, required 0/1", row_valid, pix_ready); end
      total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL single_frame_cnt: got %0d, required %0d", frame_cnt, exp_fc); end
   endtask

   task automatic test_backpressure();
      logic         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [W-1:0] d;
      logic [1:0]   i;
      int           start;
      start = xfers;
      push_frame(32'h1122_3344);
      pix_in = 32'h1122_3344; pix_valid = 1'b1; row_ready = 1'b0;
      tick();
      pix_valid = 1'b0;
      for (int c = 0; c < 40 && xfers < start + H; c++) begin
         row_ready = pat[c % 4];
         if (!row_ready) begin
            d = row_data; i = row_idx;
            tick();
            total++;
            if (row_data !== d || row_idx !== i || row_valid !== 1'b1) begin
               bad++; $display("FAIL bp_hold: got %h/%0d, required %h/%0d", row_data, row_idx, d, i);
            end
         end else begin
            tick();
         end
      end
      row_ready = 1'b1;
      exp_fc = exp_fc + 16'd1;
      total++; if (xfers !== start + H) begin bad++; $display("FAIL bp_rows: got %0d, required %0d", xfers - start, H); end
      total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL bp_frame_cnt: got %0d, required %0d", frame_cnt, exp_fc); end
   endtask

   task automatic test_back_to_back();
      push_frame(32'hDEAD_BEEF);
      push_frame(32'h0102_0408);
      pix_in = 32'hDEAD_BEEF; pix_valid = 1'b1; row_ready = 1'b1;
      tick();
      pix_in = 32'h0102_0408;
      for (int k = 0; k < 2 * H; k++) begin
         total++;
         if (row_valid !== 1'b1 || row_idx !== 2'(k % H) || pix_ready !== ((k % H) == H - 1)) begin
            bad++; $display("FAIL b2b_k%0d: got valid=%b idx=%0d ready=%b, required 1/%0d/%b",
                            k, row_valid, row_idx, pix_ready, k % H, (k % H) == H - 1);
         end
         tick();
         if (k == H - 1) pix_valid = 1'b0;
      end
      exp_fc = exp_fc + 16'd2;
      total++; if (row_valid !== 1'b0 || frame_cnt !== exp_fc) begin bad++; $display("FAIL b2b_end: got valid=%b cnt=%0d, required 0/%0d", row_valid, frame_cnt, exp_fc); end
   endtask

   task automatic test_midstream();
      push_frame(32'h8040_2010);
      push_frame(32'h5A5A_C3C3);
      pix_in = 32'h8040_2010; pix_valid = 1'b1; row_ready = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick();
      pix_in = 32'h5A5A_C3C3; pix_valid = 1'b1; row_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL mid_stall_ready: got %b, required 0", pix_ready); end
         tick();
      end
      row_ready = 1'b1;
      total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL mid_row1_ready: got %b, required 0", pix_ready); end
      tick(); tick();
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL mid_row3_ready: got %b, required 1", pix_ready); end
      tick();
      pix_valid = 1'b0; pix_in = 32'hFFFF_FFFF;
      for (int k = 0; k < H; k++) tick();
      exp_fc = exp_fc + 16'd2;
      total++; if (sb.size() !== 0 || frame_cnt !== exp_fc) begin bad++; $display("FAIL mid_end: got left=%0d cnt=%0d, required 0/%0d", sb.size(), frame_cnt, exp_fc); end
   endtask

   task automatic test_reset_midframe();
      push_frame(32'h7777_3333);
      pix_in = 32'h7777_3333; pix_valid = 1'b1; row_ready = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      sb.delete();
      exp_fc = 16'd0;
      total++; if (row_valid !== 1'b0 || frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid: got valid=%b cnt=%0d, required 0/0", row_valid, frame_cnt); end
      total++; if (pix_ready !== 1'b1 || row_idx !== 2'd0) begin bad++; $display("FAIL rst_mid_ctl: got ready=%b idx=%0d, required 1/0", pix_ready, row_idx); end
      tick();
      rst = 1'b0;
      push_frame(32'h0F1E_2D3C);
      pix_in = 32'h0F1E_2D3C; pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      total++; if (row_idx !== 2'd0 || row_valid !== 1'b1) begin bad++; $display("FAIL rst_restart: got idx=%0d valid=%b, required 0/1", row_idx, row_valid); end
      for (int k = 0; k < H; k++) tick();
      exp_fc = exp_fc + 16'd1;
      total++; if (frame_cnt !== exp_fc || sb.size() !== 0) begin bad++; $display("FAIL rst_after: got cnt=%0d left=%0d, required %0d/0", frame_cnt, sb.size(), exp_fc); end
   endtask

`ifdef PIX_ROW_PARITY_EN
   task automatic test_parity();
      logic exp_par [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      push_frame(32'h0001_07F0);
      pix_in = 32'h0001_07F0; pix_valid = 1'b1; row_ready = 1'b1;
      total++; if (row_parity !== 1'b0) begin bad++; $display("FAIL par_idle: got %b, required 0", row_parity); end
      tick();
      pix_valid = 1'b0;
      for (int k = 0; k < H; k++) begin
         total++; if (row_parity !== exp_par[k]) begin bad++; $display("FAIL par_row%0d: got %b, required %b", k, row_parity, exp_par[k]); end
         tick();
      end
      exp_fc = exp_fc + 16'd1;
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_back_to_back();
      test_midstream();
      test_reset_midframe();
`ifdef PIX_ROW_PARITY_EN
      test_parity();
`endif
      total++; if (sb.size() !== 0) begin bad++; $display("FAIL sb_drain: got %0d left, required 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
